traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/tlc_pkg.sv | 47 ++++
 rtl/tlc_ped_latch.sv | 33 +++
 rtl/traffic_phase_ctrl.sv | 175 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the traffic phase controller:
//   - tlc_state_t : phase encoding of the controller FSM
//   - tlc_dir_t   : which green a pedestrian walk phase returns to
//   - LAMP_*      : one-hot lamp encodings {red,yellow,green}
//   - T_*_DEF     : default dwell presets loaded into the external countdown
// Build option: TLC_PED_EN adds the ST_PED_WALK phase to the state enum.
// -----------------------------------------------------------------------------
package tlc_pkg;

    localparam int unsigned PRESET_W = 7;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [PRESET_W-1:0] T_GREEN_DEF  = 7'd30;
    localparam logic [PRESET_W-1:0] T_YELLOW_DEF = 7'd4;
    localparam logic [PRESET_W-1:0] T_ALLRED_DEF = 7'd2;
    localparam logic [PRESET_W-1:0] T_WALK_DEF   = 7'd10;

    typedef enum logic [2:0] {
        ST_ALL_RED_A = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_ALL_RED_B = 3'd3,
        ST_EW_GREEN  = 3'd4,
`ifdef TLC_PED_EN
        ST_EW_YELLOW = 3'd5,
        ST_PED_WALK  = 3'd6
`else
        ST_EW_YELLOW = 3'd5
`endif
    } tlc_state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } tlc_dir_t;

    // Both clearance phases behave identically apart from their successor.
    function automatic logic is_all_red(input tlc_state_t s);
        return (s == ST_ALL_RED_A) || (s == ST_ALL_RED_B);
    endfunction

endpackage

// File: rtl/tlc_ped_latch.sv
// -----------------------------------------------------------------------------
// tlc_ped_latch
// Set-dominant pedestrian request latch. A request arriving in the same cycle
// the controller consumes the previous one survives, so it is served at the
// following all-red phase.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (clears the latch)
//   i_set     : request level, sets the latch
//   i_clr     : consume pulse from the controller
//   o_pending : latched request
// -----------------------------------------------------------------------------
module tlc_ped_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_pending
);

    logic r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= i_set | (r_pending & ~i_clr);
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Two-way intersection phase sequencer driving an external countdown timer.
// Cycle: ALL_RED_A -> NS_GREEN -> NS_YELLOW -> ALL_RED_B -> EW_GREEN ->
//        EW_YELLOW -> ALL_RED_A. With TLC_PED_EN defined, a latched
//        pedestrian request diverts an all-red exit into PED_WALK, which then
//        resumes at the green that would otherwise have followed.
// Build option: TLC_PED_EN (undefined: ped_req ignored, walk tied low).
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   timer_active : external countdown nonzero
//   ped_req      : level pedestrian request
//   timer_start  : one-cycle pulse loading the countdown with timer_preset
//   timer_preset : dwell preset of the phase just entered (held between pulses)
//   ns_light     : north-south lamps {red,yellow,green}
//   ew_light     : east-west lamps {red,yellow,green}
//   walk         : pedestrian walk lamp
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import tlc_pkg::*;
#(
    parameter logic [6:0] T_GREEN  = T_GREEN_DEF,
    parameter logic [6:0] T_YELLOW = T_YELLOW_DEF,
    parameter logic [6:0] T_ALLRED = T_ALLRED_DEF,
    parameter logic [6:0] T_WALK   = T_WALK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_active,
    input  logic       ped_req,
    output logic       timer_start,
    output logic [6:0] timer_preset,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    tlc_state_t r_state;
    tlc_state_t w_next;
    logic       r_timer_start;
    logic [6:0] r_timer_preset;
    logic       w_advance;
    logic       w_ped_set;
    logic       w_ped_clr;
    logic       w_ped_pending;

    function automatic logic [6:0] preset_of(input tlc_state_t s);
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   return T_GREEN;
            ST_NS_YELLOW, ST_EW_YELLOW: return T_YELLOW;
`ifdef TLC_PED_EN
            ST_PED_WALK:                return T_WALK;
`endif
            default:                    return T_ALLRED;
        endcase
    endfunction

    // The countdown has not yet seen the load while timer_start is high, so
    // timer_active is only trusted in cycles after the pulse.
    assign w_advance = !r_timer_start && !timer_active;

`ifdef TLC_PED_EN
    tlc_dir_t r_pend_dir;
    logic     w_take_walk;

    always_comb begin
        w_next      = ST_ALL_RED_A;
        w_take_walk = 1'b0;
        case (r_state)
            ST_ALL_RED_A: begin
                w_next = ST_NS_GREEN;
                if (w_ped_pending) begin
                    w_next      = ST_PED_WALK;
                    w_take_walk = 1'b1;
                end
            end
            ST_NS_GREEN:  w_next = ST_NS_YELLOW;
            ST_NS_YELLOW: w_next = ST_ALL_RED_B;
            ST_ALL_RED_B: begin
                w_next = ST_EW_GREEN;
                if (w_ped_pending) begin
                    w_next      = ST_PED_WALK;
                    w_take_walk = 1'b1;
                end
            end
            ST_EW_GREEN:  w_next = ST_EW_YELLOW;
            ST_EW_YELLOW: w_next = ST_ALL_RED_A;
            ST_PED_WALK:  w_next = (r_pend_dir == DIR_EW) ? ST_EW_GREEN : ST_NS_GREEN;
            default:      w_next = ST_ALL_RED_A;
        endcase
    end

    assign w_ped_set = ped_req;
    assign w_ped_clr = w_advance & w_take_walk & is_all_red(r_state);
`else
    always_comb begin
        w_next = ST_ALL_RED_A;
        case (r_state)
            ST_ALL_RED_A: w_next = ST_NS_GREEN;
            ST_NS_GREEN:  w_next = ST_NS_YELLOW;
            ST_NS_YELLOW: w_next = ST_ALL_RED_B;
            ST_ALL_RED_B: w_next = ST_EW_GREEN;
            ST_EW_GREEN:  w_next = ST_EW_YELLOW;
            ST_EW_YELLOW: w_next = ST_ALL_RED_A;
            default:      w_next = ST_ALL_RED_A;
        endcase
    end

    // Latch is held idle; the request input and walk preset have no effect.
    logic w_unused_ped;
    assign w_ped_set    = 1'b0;
    assign w_ped_clr    = 1'b0;
    assign w_unused_ped = ped_req | w_ped_pending | (|T_WALK);
`endif

    tlc_ped_latch u_ped_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (w_ped_set),
        .i_clr     (w_ped_clr),
        .o_pending (w_ped_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_ALL_RED_A;
            r_timer_start  <= 1'b0;
            r_timer_preset <= '0;
`ifdef TLC_PED_EN
            r_pend_dir     <= DIR_NS;
`endif
        end else begin
            r_timer_start <= 1'b0;
            if (w_advance) begin
                r_state        <= w_next;
                r_timer_start  <= 1'b1;
                r_timer_preset <= preset_of(w_next);
`ifdef TLC_PED_EN
                // Remember which green the walk interrupted.
                if (w_take_walk) begin
                    r_pend_dir <= (r_state == ST_ALL_RED_B) ? DIR_EW : DIR_NS;
                end
`endif
            end
        end
    end

    // Lamps decode only from the state register; every non-driving phase,
    // including the walk, shows red on both approaches.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (r_state)
            ST_NS_GREEN:  ns_light = LAMP_GREEN;
            ST_NS_YELLOW: ns_light = LAMP_YELLOW;
            ST_EW_GREEN:  ew_light = LAMP_GREEN;
            ST_EW_YELLOW: ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

`ifdef TLC_PED_EN
    assign walk = (r_state == ST_PED_WALK);
`else
    assign walk = 1'b0;
`endif

    assign timer_start  = r_timer_start;
    assign timer_preset = r_timer_preset;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

`ifdef TLC_PED_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    localparam int P_ARA = 0, P_NSG = 1, P_NSY = 2, P_ARB = 3, P_EWG = 4, P_EWY = 5, P_WALK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped0 = 1'b0;
    logic       timer_active, timer_start, walk;
    logic [6:0] timer_preset;
    logic [2:0] ns_light, ew_light;
    logic       timer_active0, timer_start0, walk0;
    logic [6:0] timer_preset0;
    logic [2:0] ns_light0, ew_light0;
    logic [6:0] r_cnt, r_cnt0;

    int n_vec = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(.T_GREEN(7'd5), .T_YELLOW(7'd2), .T_ALLRED(7'd1), .T_WALK(7'd3)) dut (
        .clk(clk), .rst_n(rst_n), .timer_active(timer_active), .ped_req(ped_req),
        .timer_start(timer_start), .timer_preset(timer_preset),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk));

    traffic_phase_ctrl #(.T_GREEN(7'd5), .T_YELLOW(7'd2), .T_ALLRED(7'd0), .T_WALK(7'd3)) dut0 (
        .clk(clk), .rst_n(rst_n), .timer_active(timer_active0), .ped_req(ped0),
        .timer_start(timer_start0), .timer_preset(timer_preset0),
        .ns_light(ns_light0), .ew_light(ew_light0), .walk(walk0));

    // Load-on-start, decrement-to-zero countdowns paired with each controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (timer_start) r_cnt <= timer_preset;
        else if (r_cnt != 0) r_cnt <= r_cnt - 7'd1;
    end
    assign timer_active = (r_cnt != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt0 <= '0;
        else if (timer_start0) r_cnt0 <= timer_preset0;
        else if (r_cnt0 != 0) r_cnt0 <= r_cnt0 - 7'd1;
    end
    assign timer_active0 = (r_cnt0 != 0);

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: phases and their dwell lengths -------
    typedef struct {
        int ph;       // current phase
        int rem;      // cycles left in the phase, including the current one
        bit start;    // first cycle of a phase
        int preset;   // preset shown on the timer bus
        bit flag;     // outstanding pedestrian request
        bit pend_ew;  // walk returns to EW green
    } m_t;

    m_t m;

    function automatic int m_preset(input int ph);
        case (ph)
            P_NSG, P_EWG: return 5;
            P_NSY, P_EWY: return 2;
            P_WALK:       return 3;
            default:      return 1;
        endcase
    endfunction

    function automatic int m_ns(input int ph);
        return (ph == P_NSG) ? 1 : (ph == P_NSY) ? 2 : 4;
    endfunction

    function automatic int m_ew(input int ph);
        return (ph == P_EWG) ? 1 : (ph == P_EWY) ? 2 : 4;
    endfunction

    function automatic m_t m_reset();
        m_t r;
        r.ph = P_ARA; r.rem = 1; r.start = 0; r.preset = 0; r.flag = 0; r.pend_ew = 0;
        return r;
    endfunction

    function automatic m_t model_next(input m_t s, input logic ped);
        m_t n;
        bit walk_now;
        int nx;
        n = s;
        n.start = 0;
        walk_now = 0;
        nx = P_ARA;
        if (s.rem <= 1) begin
            case (s.ph)
                P_ARA: if (PED_ON && s.flag) begin nx = P_WALK; walk_now = 1; n.pend_ew = 0; end
                       else nx = P_NSG;
                P_NSG: nx = P_NSY;
                P_NSY: nx = P_ARB;
                P_ARB: if (PED_ON && s.flag) begin nx = P_WALK; walk_now = 1; n.pend_ew = 1; end
                       else nx = P_EWG;
                P_EWG: nx = P_EWY;
                P_EWY: nx = P_ARA;
                default: nx = s.pend_ew ? P_EWG : P_NSG;
            endcase
            n.ph = nx;
            n.preset = m_preset(nx);
            n.rem = n.preset + 2;
            n.start = 1;
        end else begin
            n.rem = s.rem - 1;
        end
        n.flag = PED_ON && (ped || (s.flag && !walk_now));
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= model_next(m, ped_req);
    end

    // Cycle-by-cycle comparison of the main controller against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ns", ns_light, m_ns(m.ph));
            check("model_ew", ew_light, m_ew(m.ph));
            check("model_walk", walk, (m.ph == P_WALK) ? 1 : 0);
            check("model_start", timer_start, m.start);
            check("model_preset", timer_preset, m.preset);
            check("excl_main", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
        end
    end

    // Zero-length all-red instance: clearance runs of 2, isolated start pulses.
    int  run0;
    bit  run0_valid;
    bit  prev_start0;
    always @(negedge clk) begin
        if (!rst_n || !chk_en) begin
            run0 <= 0;
            run0_valid <= 1'b0;
            prev_start0 <= 1'b0;
        end else begin
            check("d0_start_pulse", prev_start0 && timer_start0, 0);
            check("excl_d0", (ns_light0 != 3'b100) && (ew_light0 != 3'b100), 0);
            prev_start0 <= timer_start0;
            if (ns_light0 == 3'b100 && ew_light0 == 3'b100) begin
                run0 <= run0 + 1;
            end else begin
                if (run0_valid && run0 != 0) check("d0_allred_dwell", run0, 2);
                run0 <= 0;
                run0_valid <= 1'b1;
            end
        end
    end

    // ---------------- free-run phase table ---------------------------------
    typedef struct {
        logic       ped;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wlk;
        logic [6:0] preset;
        int         dwell;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, walks;
        bit found;

        tbl[0] = '{1'b0, 3'b001, 3'b100, 1'b0, 7'd5, 7};
        tbl[1] = '{1'b0, 3'b010, 3'b100, 1'b0, 7'd2, 4};
        tbl[2] = '{1'b0, 3'b100, 3'b100, 1'b0, 7'd1, 3};
        tbl[3] = '{1'b0, 3'b100, 3'b001, 1'b0, 7'd5, 7};
        tbl[4] = '{1'b0, 3'b100, 3'b010, 1'b0, 7'd2, 4};
        tbl[5] = '{1'b0, 3'b100, 3'b100, 1'b0, 7'd1, 3};

        // Reset state
        tick();
        chk_en = 1'b1;
        check("rst_ns", ns_light, 3'b100);
        check("rst_ew", ew_light, 3'b100);
        check("rst_start", timer_start, 0);
        check("rst_preset", timer_preset, 0);
        check("rst_walk", walk, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release enters NS green
        tick();
        check("rel_ns", ns_light, 3'b001);
        check("rel_ew", ew_light, 3'b100);
        check("rel_start", timer_start, 1);
        check("rel_preset", timer_preset, 5);

        // Two full periods, measured phase by phase
        for (int p = 0; p < 12; p++) begin
            ped_req = tbl[p % 6].ped;
            check("tbl_ns", ns_light, tbl[p % 6].ns);
            check("tbl_ew", ew_light, tbl[p % 6].ew);
            check("tbl_walk", walk, tbl[p % 6].wlk);
            check("tbl_preset", timer_preset, tbl[p % 6].preset);
            check("tbl_start", timer_start, 1);
            n = 0;
            do begin
                tick();
                n++;
            end while (!timer_start && n < 40);
            check("tbl_dwell", n, tbl[p % 6].dwell);
            $display("phase %0d: ns=%b ew=%b dwell=%0d", p, tbl[p % 6].ns, tbl[p % 6].ew, n);
        end

        // One-cycle pedestrian request during NS green
        tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        walks = 0;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            if (walk) begin
                walks++;
                check("walk_lamps", {ns_light, ew_light}, 6'b100100);
            end
            if (ew_light == 3'b001) found = 1;
        end
        check("ped_reached_ewg", found, 1);
        check("ped_walk_cycles", walks, PED_ON ? 5 : 0);
        $display("ped request: walk cycles=%0d", walks);

        // Following period has no second walk and is 28 cycles
        walks = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (walk) walks++;
        end while (!(ew_light == 3'b001 && timer_start) && n < 60);
        check("period", n, 28);
        check("no_second_walk", walks, 0);
        $display("period after request: %0d cycles", n);

        // Reset mid NS yellow
        n = 0;
        while (ns_light != 3'b010 && n < 60) begin
            tick();
            n++;
        end
        check("reach_nsy", ns_light, 3'b010);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ns", ns_light, 3'b100);
        check("midrst_ew", ew_light, 3'b100);
        check("midrst_start", timer_start, 0);
        check("midrst_walk", walk, 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rerel_ns", ns_light, 3'b001);
        check("rerel_start", timer_start, 1);
        check("rerel_preset", timer_preset, 5);
        tick();
        check("rerel_start_clr", timer_start, 0);
        $display("mid-phase reset recovered");

        // Randomized pedestrian traffic against the model
        for (int c = 0; c < 800; c++) begin
            tick();
            ped_req = ($urandom_range(0, 15) == 0);
        end
        ped_req = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        $display("random run done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
